// File: rtl/reflet_float_acc.sv
// Floating-point accumulator: folds a stream of operands into one running
// sum through a single float adder, then holds the result until taken.
// The adder lives in this file as well so the block stands on its own.

// Combinational float adder: out = in1 + in2, or in1 - in2 when enable_sub.
// Truncating rounding, subnormals flushed to zero, no NaN handling.
module reflet_float_add #(
   parameter int float_size = 32
) (
   input  logic                  enable_add,
   input  logic                  enable_sub,
   input  logic [float_size-1:0] in1,
   input  logic [float_size-1:0] in2,
   output logic [float_size-1:0] out
);
   localparam int EW = (float_size == 64) ? 11 : (float_size == 16) ? 5 : 8;
   localparam int MW = float_size - 1 - EW;
   // carry + hidden one + mantissa + 3 guard bits
   localparam int SW = MW + 5;
   localparam int EMAX = (1 << EW) - 1;

   logic [float_size-1:0] b, big, sml;
   logic [SW-1:0]         ma, mb, sum, nrm;
   int                    diff, lead, e;

   // align the smaller operand, add or subtract magnitudes, renormalise
   always_comb begin
      b = in2;
      b[float_size-1] = in2[float_size-1] ^ enable_sub;
      if (in1[float_size-2:0] >= b[float_size-2:0]) begin
         big = in1;
         sml = b;
      end else begin
         big = b;
         sml = in1;
      end
      ma = '0;
      mb = '0;
      if (big[float_size-2:MW] != '0) ma = {2'b01, big[MW-1:0], 3'b000};
      if (sml[float_size-2:MW] != '0) mb = {2'b01, sml[MW-1:0], 3'b000};
      diff = int'(big[float_size-2:MW]) - int'(sml[float_size-2:MW]);
      mb = (diff >= SW) ? '0 : (mb >> diff);
      sum = (big[float_size-1] == sml[float_size-1]) ? (ma + mb) : (ma - mb);
      lead = -1;
      for (int i = 0; i < SW; i++)
         if (sum[i]) lead = i;
      nrm = (lead > SW - 2) ? (sum >> 1) : (sum << (SW - 2 - lead));
      e = int'(big[float_size-2:MW]) + lead - (SW - 2);
      out = '0;
      if (!enable_add || lead < 0 || e <= 0)
         out = '0;
      else if (e >= EMAX)
         out = {big[float_size-1], {EW{1'b1}}, {MW{1'b0}}};
      else
         out = {big[float_size-1], EW'(e), MW'(nrm >> 3)};
   end
endmodule

module reflet_float_acc #(
   parameter int float_size = 32,
   parameter int count_size = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [float_size-1:0] in_data,
   input  logic                  in_sub,
   input  logic                  in_last,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  clear,
   output logic [float_size-1:0] acc_value,
   output logic [count_size-1:0] acc_count,
   output logic                  out_valid,
   input  logic                  out_ready
);
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t                state;
   logic [float_size-1:0] acc, sum;

   reflet_float_add #(.float_size(float_size)) u_add (
      .enable_add (1'b1),
      .enable_sub (in_sub),
      .in1        (acc),
      .in2        (in_data),
      .out        (sum)
   );

   // handshake flags are pure functions of state, so no input reaches them
   assign in_ready  = (state != DONE);
   assign out_valid = (state == DONE);
   assign acc_value = acc;

   // sequence FSM: first operand bypasses the adder, later ones go through it
   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         state     <= IDLE;
         acc       <= '0;
         acc_count <= '0;
      end else begin
         case (state)
            IDLE:
               if (in_valid) begin
                  acc       <= {in_data[float_size-1] ^ in_sub, in_data[float_size-2:0]};
                  acc_count <= count_size'(1);
                  state     <= in_last ? DONE : ACCUM;
               end
            ACCUM:
               if (in_valid) begin
                  acc <= sum;
                  if (acc_count != '1) acc_count <= acc_count + count_size'(1);
                  state <= in_last ? DONE : ACCUM;
               end
            DONE:
               if (out_ready) begin
                  state     <= IDLE;
                  acc       <= '0;
                  acc_count <= '0;
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_reflet_float_acc.sv
// Bench for reflet_float_acc: directed scenarios followed by random traffic,
// all checked against a real-arithmetic model of the accumulator.
module tb_reflet_float_acc;
   logic        clk = 1'b0;
   logic        reset, in_sub, in_last, in_valid, clear, out_ready;
   logic [31:0] in_data;
   logic        in_ready, out_valid;
   logic [31:0] acc_value;
   logic [15:0] acc_count;

   int errs = 0, checks = 0;

   // reference model: a real-valued sum plus sequence bookkeeping
   real m_sum = 0.0;
   int  m_cnt = 0;
   bit  m_done = 1'b0, m_started = 1'b0;

   reflet_float_acc #(.float_size(32), .count_size(16)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_sub(in_sub),
      .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
      .clear(clear), .acc_value(acc_value), .acc_count(acc_count),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // exactly representable real -> IEEE single bits
   function automatic logic [31:0] r2b(input real v);
      logic s;
      real  a;
      int   e;
      if (v == 0.0) return 32'h0;
      s = (v < 0.0);
      a = s ? -v : v;
      e = 0;
      while (a >= 2.0) begin a = a / 2.0; e++; end
      while (a < 1.0)  begin a = a * 2.0; e--; end
      return {s, 8'(e + 127), 23'($rtoi((a - 1.0) * 8388608.0))};
   endfunction

   // IEEE single bits (normal numbers) -> real
   function automatic real b2r(input logic [31:0] w);
      real m;
      int  e;
      if (w[30:23] == 8'h0) return 0.0;
      m = 1.0 + real'(w[22:0]) / 8388608.0;
      e = int'(w[30:23]) - 127;
      while (e > 0) begin m = m * 2.0; e--; end
      while (e < 0) begin m = m / 2.0; e++; end
      return w[31] ? -m : m;
   endfunction

   // one clock: compare outputs against the model, then advance the model
   task automatic cyc(input bit do_chk);
      real v;
      @(negedge clk);
      if (do_chk) begin
         chk("in_ready", 32'(in_ready), 32'(!m_done));
         chk("out_valid", 32'(out_valid), 32'(m_done));
         chk("acc_value", acc_value, r2b(m_sum));
         chk("acc_count", 32'(acc_count), 32'(m_cnt));
      end
      if (!reset || clear || (m_done && out_ready)) begin
         m_done = 0; m_started = 0; m_sum = 0.0; m_cnt = 0;
      end else if (!m_done && in_valid) begin
         v = in_sub ? -b2r(in_data) : b2r(in_data);
         m_sum = m_started ? m_sum + v : v;
         if (m_cnt < 65535) m_cnt++;
         m_started = 1;
         if (in_last) m_done = 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic [31:0] d, input bit sub, input bit last);
      in_valid = 1; in_data = d; in_sub = sub; in_last = last;
      cyc(1);
      in_valid = 0; in_sub = 0; in_last = 0;
   endtask

   task automatic take();
      out_ready = 1;
      cyc(1);
      out_ready = 0;
   endtask

   initial begin
      reset = 0; clear = 0; out_ready = 0; in_valid = 0;
      in_sub = 0; in_last = 0; in_data = 32'h0;
      @(posedge clk); #1;
      cyc(0);
      cyc(1);                         // reset state
      reset = 1;
      cyc(1);

      // single operand
      op(32'h3F800000, 0, 1);
      chk("single_val", acc_value, 32'h3F800000);
      chk("single_cnt", 32'(acc_count), 32'd1);
      chk("single_ov", 32'(out_valid), 32'd1);
      take();

      // back-to-back add
      op(32'h3F800000, 0, 0);
      op(32'h40000000, 0, 1);
      chk("b2b_val", acc_value, 32'h40400000);
      chk("b2b_cnt", 32'(acc_count), 32'd2);
      take();
      op(32'h3F000000, 1, 0);
      op(32'h40000000, 0, 1);
      chk("subfirst_val", acc_value, 32'h3FC00000);
      take();

      // cancellation and negated single operand
      op(32'h3F800000, 0, 0);
      op(32'h3F800000, 1, 1);
      chk("cancel_val", acc_value, 32'h00000000);
      take();
      op(32'h3F800000, 1, 1);
      chk("neg_val", acc_value, 32'hBF800000);

      // hold in DONE with an operand pending, then release
      in_valid = 1; in_data = 32'h40000000; in_last = 1;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk("hold_rdy", 32'(in_ready), 32'd0);
         chk("hold_val", acc_value, 32'hBF800000);
      end
      out_ready = 1;
      cyc(1);
      out_ready = 0;
      chk("rel_val", acc_value, 32'h0);
      chk("rel_rdy", 32'(in_ready), 32'd1);
      cyc(1);
      in_valid = 0; in_last = 0;
      chk("pend_val", acc_value, 32'h40000000);
      chk("pend_cnt", 32'(acc_count), 32'd1);
      take();

      // reset mid-sequence
      op(32'h3F800000, 0, 0);
      op(32'h40000000, 0, 0);
      reset = 0;
      cyc(1);
      reset = 1;
      chk("rst_val", acc_value, 32'h0);
      chk("rst_cnt", 32'(acc_count), 32'd0);
      chk("rst_ov", 32'(out_valid), 32'd0);
      op(32'h40000000, 0, 1);
      chk("after_rst", acc_value, 32'h40000000);
      take();

      // clear in ACCUM with an operand offered, then clear in DONE
      op(32'h3F800000, 0, 0);
      clear = 1; in_valid = 1; in_data = 32'h40000000;
      cyc(1);
      clear = 0; in_valid = 0;
      chk("clr_val", acc_value, 32'h0);
      chk("clr_cnt", 32'(acc_count), 32'd0);
      op(32'h40400000, 0, 1);
      clear = 1;
      cyc(1);
      clear = 0;
      chk("clr_done_ov", 32'(out_valid), 32'd0);

      // random traffic with exactly representable operands
      for (int n = 0; n < 3000; n++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_sub    = $urandom_range(0, 1);
         in_last   = ($urandom_range(0, 4) == 0);
         out_ready = $urandom_range(0, 1);
         clear     = ($urandom_range(0, 49) == 0);
         reset     = ($urandom_range(0, 99) != 0);
         in_data   = r2b(real'($urandom_range(1, 4000)) * 0.25 *
                         ($urandom_range(0, 1) ? -1.0 : 1.0));
         cyc(1);
      end
      reset = 1; clear = 0; in_valid = 0; out_ready = 0;
      cyc(1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/reflet_float_acc.md
REFLET_FLOAT_ACC -- requirements
Module: reflet_float_acc

Interface
REQ-001 The module SHALL have parameter float_size, default 32, giving the float word width in the same format as the float adder.
REQ-002 The module SHALL have parameter count_size, default 16, giving the width of the operand counter.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The module SHALL have port in_data, input, float_size bits: operand to accumulate.
REQ-006 The module SHALL have port in_sub, input, 1 bit: when high, subtract this operand instead of adding it.
REQ-007 The module SHALL have port in_last, input, 1 bit: marks this operand as the final one of a sequence.
REQ-008 The module SHALL have port in_valid, input, 1 bit: operand fields are valid.
REQ-009 The module SHALL have port in_ready, output, 1 bit: the block accepts an operand this cycle.
REQ-010 The module SHALL have port clear, input, 1 bit: abort the sequence and discard the running sum.
REQ-011 The module SHALL have port acc_value, output, float_size bits: the running or final sum.
REQ-012 The module SHALL have port acc_count, output, count_size bits: the number of operands accepted in the current sequence.
REQ-013 The module SHALL have port out_valid, output, 1 bit: acc_value holds a final result.
REQ-014 The module SHALL have port out_ready, input, 1 bit: the consumer takes the result.

Function
REQ-015 The block SHALL instantiate exactly one reflet_float_add, driven as: in1 = acc register, in2 = in_data, enable_add = 1, enable_sub = in_sub; the block SHALL contain no other float arithmetic.
REQ-016 The FSM SHALL have states IDLE (no operand yet), ACCUM (at least one operand taken), and DONE (result held).
REQ-017 in_ready SHALL equal 1 in IDLE and ACCUM and 0 in DONE; an operand is accepted only on a cycle where in_valid and in_ready are both 1.
REQ-018 On acceptance in IDLE, the acc register SHALL load in_data directly, bypassing the adder, with the sign bit inverted if in_sub is 1; acc_count SHALL load 1.
REQ-019 On acceptance in ACCUM, the acc register SHALL load the adder sum; acc_count SHALL increment, saturating at all-ones.
REQ-020 On acceptance: if in_last is 1, next state SHALL be DONE; otherwise next state SHALL be ACCUM.
REQ-021 The block SHALL sustain one operand per cycle, and out_valid SHALL rise on the cycle after the last operand is accepted (1-cycle latency).
REQ-022 out_valid SHALL be 1 only in DONE; acc_value and acc_count SHALL remain stable while out_valid is 1 and out_ready is 0.
REQ-023 In DONE with out_ready = 1: next state SHALL be IDLE, acc SHALL be cleared to 0, and acc_count SHALL be cleared to 0; in_ready SHALL be 1 on the following cycle.
REQ-024 clear = 1 in any state SHALL force next state IDLE with acc and acc_count set to 0; any operand offered that cycle is not accepted, and a DONE result is dropped.
REQ-025 Priority SHALL be: reset, then clear, then handshakes.
REQ-026 acc_value SHALL always reflect the acc register; outputs SHALL be registered or depend on state only, with no combinational path from in_* to out_*.

Reset
REQ-027 While reset = 0 at a clock edge: state SHALL become IDLE, acc SHALL become 0, acc_count SHALL become 0, and out_valid SHALL become 0; in_ready SHALL be 1 from the first cycle after reset deasserts.
REQ-028 Reset asserted mid-sequence or in DONE SHALL discard all progress, with no result emitted.

Verification
REQ-029 Single operand 0x3F800000 with in_last = 1 -> next cycle out_valid = 1, acc_value = 0x3F800000, acc_count = 1.
REQ-030 Back-to-back operands 0x3F800000 then 0x40000000 (last) -> acc_value = 0x40400000, acc_count = 2; then 0x3F000000 with in_sub = 1 (first) and 0x40000000 (last) -> 0x3FC00000.
REQ-031 Operand 0x3F800000 then 0x3F800000 with in_sub = 1 and last -> acc_value = 0x00000000; single 0x3F800000 with in_sub = 1 and last -> 0xBF800000.
REQ-032 In DONE, hold out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, acc_value unchanged; then out_ready = 1 -> IDLE, acc_value = 0, in_ready = 1 next cycle, and the pending operand is accepted as a first operand.
REQ-033 Reset = 0 after 2 of 4 operands -> acc_value = 0, acc_count = 0, out_valid = 0; the new sequence 0x40000000 (last) -> 0x40000000.
REQ-034 clear = 1 with in_valid = 1 in ACCUM -> operand not accepted, IDLE, acc_value = 0; clear = 1 in DONE -> out_valid drops next cycle.
